niosiisystem_nios2_gen2_0_cpu_debug_ocimem_ctrl: RTL and testbench



---
 rtl/niosiisystem_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_niosiisystem_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosiisystem_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// OCI debug memory sequencer, sysclk domain.
// Turns debug-slave strobes into single timed-out memory transactions.
module niosiisystem_nios2_gen2_0_cpu_debug_ocimem_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    // Counter must hold values up to TIMEOUT-1.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [31:0]         r_wdata;
    logic [31:0]         w_wdata_nxt;
    logic [31:0]         r_mon;
    logic [31:0]         w_mon_nxt;
    logic                r_rd;
    logic                w_rd_nxt;
    logic                r_wr;
    logic                w_wr_nxt;
    logic                r_ready;
    logic                w_ready_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic                w_strobe;
    logic                w_last;
    logic [ADDR_W-1:0]   w_jdo_addr;
    logic [31:0]         w_jdo_data;
    logic                w_jdo_rd;
    logic                w_unused;

    assign w_strobe   = take_action_ocimem_a
                      | take_action_ocimem_b
                      | take_no_action_ocimem_a;
    // Last permitted request cycle: an ack here still counts as success.
    assign w_last     = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_jdo_addr = jdo[ADDR_W+25:26];
    assign w_jdo_data = jdo[34:3];
    assign w_jdo_rd   = jdo[34];
    assign w_unused   = ^{jdo[37:35], jdo[2:0]};

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_mon_nxt   = r_mon;
        w_rd_nxt    = r_rd;
        w_wr_nxt    = r_wr;
        w_ready_nxt = r_ready;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;

        unique case (r_state)
            S_IDLE: begin
                if (take_action_ocimem_a) begin
                    w_addr_nxt = w_jdo_addr;
                    w_err_nxt  = 1'b0;
                    if (w_jdo_rd) begin
                        w_state_nxt = S_RD;
                        w_rd_nxt    = 1'b1;
                        w_ready_nxt = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                end else if (take_action_ocimem_b) begin
                    w_wdata_nxt = w_jdo_data;
                    w_state_nxt = S_WR;
                    w_wr_nxt    = 1'b1;
                    w_ready_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                end else if (take_no_action_ocimem_a) begin
                    w_state_nxt = S_RD;
                    w_rd_nxt    = 1'b1;
                    w_ready_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end

            S_RD, S_WR: begin
                // Commands cannot queue; flag them so the host retries.
                if (w_strobe) begin
                    w_err_nxt = 1'b1;
                end
                if (mem_ack) begin
                    w_state_nxt = S_IDLE;
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                    w_ready_nxt = 1'b1;
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    if (r_state == S_RD) begin
                        w_mon_nxt = mem_rdata;
                    end
                end else if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                    w_ready_nxt = 1'b1;
                    w_err_nxt   = 1'b1;
                    if (r_state == S_RD) begin
                        w_mon_nxt = TIMEOUT_DATA;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_rd_nxt    = 1'b0;
                w_wr_nxt    = 1'b0;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mon   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_ready <= 1'b1;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_mon   <= w_mon_nxt;
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
            r_ready <= w_ready_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign mem_addr      = r_addr;
    assign mem_rd        = r_rd;
    assign mem_wr        = r_wr;
    assign mem_wdata     = r_wdata;
    assign MonDReg       = r_mon;
    assign monitor_ready = r_ready;
    assign monitor_error = r_err;

endmodule

// File: tb/tb_niosiisystem_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// Bench for the OCI memory sequencer.
// Directed scenarios followed by random traffic against a transaction model.
module tb_niosiisystem_nios2_gen2_0_cpu_debug_ocimem_ctrl;

    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        ta_a;
    logic        ta_b;
    logic        tn_a;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    niosiisystem_nios2_gen2_0_cpu_debug_ocimem_ctrl #(
        .ADDR_W (8),
        .TIMEOUT(TO)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .jdo                    (jdo),
        .take_action_ocimem_a   (ta_a),
        .take_action_ocimem_b   (ta_b),
        .take_no_action_ocimem_a(tn_a),
        .mem_addr               (mem_addr),
        .mem_rd                 (mem_rd),
        .mem_wr                 (mem_wr),
        .mem_wdata              (mem_wdata),
        .mem_rdata              (mem_rdata),
        .mem_ack                (mem_ack),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int rd_cycles;
    int wr_cycles;

    // Transaction model: what kind of access is outstanding and
    // how many cycles its request has been visible on the port.
    typedef enum int { T_NONE, T_READ, T_WRITE } txn_t;
    txn_t        m_txn;
    int          m_held;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_mon;
    logic        m_ready;
    logic        m_err;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_txn   = T_NONE;
        m_held  = 0;
        m_addr  = '0;
        m_wdata = '0;
        m_mon   = '0;
        m_ready = 1'b1;
        m_err   = 1'b0;
    endtask

    task automatic model_start(input txn_t t);
        m_txn   = t;
        m_held  = 1;
        m_ready = 1'b0;
    endtask

    task automatic model_cycle(input logic a, input logic b,
                               input logic n, input logic [37:0] j,
                               input logic ack, input logic [31:0] rdat,
                               input logic rst);
        if (rst) begin
            model_reset();
        end else if (m_txn != T_NONE) begin
            if (a || b || n) m_err = 1'b1;
            if (ack) begin
                if (m_txn == T_READ) m_mon = rdat;
                m_addr  = m_addr + 8'd1;
                m_txn   = T_NONE;
                m_ready = 1'b1;
            end else if (m_held == TO) begin
                if (m_txn == T_READ) m_mon = 32'hDEAD_BEEF;
                m_txn   = T_NONE;
                m_ready = 1'b1;
                m_err   = 1'b1;
            end else begin
                m_held++;
            end
        end else if (a) begin
            m_addr = j[33:26];
            m_err  = 1'b0;
            if (j[34]) model_start(T_READ);
        end else if (b) begin
            m_wdata = j[34:3];
            model_start(T_WRITE);
        end else if (n) begin
            model_start(T_READ);
        end
    endtask

    task automatic compare_all();
        check("mem_addr", {24'd0, mem_addr}, {24'd0, m_addr});
        check("mem_rd", {31'd0, mem_rd}, {31'd0, m_txn == T_READ});
        check("mem_wr", {31'd0, mem_wr}, {31'd0, m_txn == T_WRITE});
        check("mem_wdata", mem_wdata, m_wdata);
        check("MonDReg", MonDReg, m_mon);
        check("ready", {31'd0, monitor_ready}, {31'd0, m_ready});
        check("error", {31'd0, monitor_error}, {31'd0, m_err});
    endtask

    task automatic step(input logic a, input logic b, input logic n,
                        input logic [37:0] j, input logic ack,
                        input logic [31:0] rdat, input logic rst);
        ta_a      = a;
        ta_b      = b;
        tn_a      = n;
        jdo       = j;
        mem_ack   = ack;
        mem_rdata = rdat;
        reset     = rst;
        model_cycle(a, b, n, j, ack, rdat, rst);
        @(posedge clk);
        #1;
        compare_all();
        if (mem_rd) rd_cycles++;
        if (mem_wr) wr_cycles++;
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 1'b0, 1'b0, 38'd0, ack, 32'd0, 1'b0);
    endtask

    function automatic logic [37:0] mk_addr(input logic rd,
                                            input logic [7:0] a);
        logic [37:0] j;
        j        = '0;
        j[34]    = rd;
        j[33:26] = a;
        return j;
    endfunction

    function automatic logic [37:0] mk_data(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        ta_a = 0; ta_b = 0; tn_a = 0; jdo = '0;
        mem_ack = 0; mem_rdata = '0; reset = 1;

        step(0, 0, 0, 38'd0, 0, 32'd0, 1);
        step(0, 0, 0, 38'd0, 0, 32'd0, 1);
        check("rst_ready", {31'd0, monitor_ready}, 32'd1);
        check("rst_mon", MonDReg, 32'd0);

        // Read at 0x10, ack in the third request cycle.
        rd_cycles = 0;
        step(1, 0, 0, mk_addr(1, 8'h10), 0, 32'd0, 0);
        idle(0);
        idle(0);
        step(0, 0, 0, 38'd0, 1, 32'hCAFE_F00D, 0);
        check("rd3_cycles", rd_cycles, 32'd3);
        check("rd3_mon", MonDReg, 32'hCAFE_F00D);
        check("rd3_ready", {31'd0, monitor_ready}, 32'd1);
        check("rd3_addr", {24'd0, mem_addr}, 32'h11);

        // Write at 0xFF, immediate ack, address wraps.
        wr_cycles = 0;
        step(1, 0, 0, mk_addr(0, 8'hFF), 0, 32'd0, 0);
        step(0, 1, 0, mk_data(32'h1234_5678), 0, 32'd0, 0);
        check("wr_data", mem_wdata, 32'h1234_5678);
        idle(1);
        check("wr_cycles", wr_cycles, 32'd1);
        check("wr_wrap", {24'd0, mem_addr}, 32'h00);
        check("wr_err", {31'd0, monitor_error}, 32'd0);

        // Read timeout.
        rd_cycles = 0;
        step(1, 0, 0, mk_addr(1, 8'h20), 0, 32'd0, 0);
        for (int i = 0; i < TO; i++) idle(0);
        check("to_cycles", rd_cycles, TO);
        check("to_mon", MonDReg, 32'hDEAD_BEEF);
        check("to_err", {31'd0, monitor_error}, 32'd1);
        check("to_addr", {24'd0, mem_addr}, 32'h20);
        step(1, 0, 0, mk_addr(0, 8'h20), 0, 32'd0, 0);
        check("to_clr", {31'd0, monitor_error}, 32'd0);

        // Read strobe while a write is pending is dropped.
        rd_cycles = 0;
        wr_cycles = 0;
        step(0, 1, 0, mk_data(32'hAAAA_5555), 0, 32'd0, 0);
        step(0, 0, 1, 38'd0, 0, 32'd0, 0);
        idle(1);
        idle(0);
        check("ovr_err", {31'd0, monitor_error}, 32'd1);
        check("ovr_wr", wr_cycles, 32'd2);
        check("ovr_rd", rd_cycles, 32'd0);
        check("ovr_addr", {24'd0, mem_addr}, 32'h21);

        // Address strobe beats write strobe.
        wr_cycles = 0;
        step(1, 1, 0, mk_addr(0, 8'h40) | mk_data(32'h0000_0F0F) &
             ~(38'd1 << 34), 0, 32'd0, 0);
        idle(0);
        check("pri_addr", {24'd0, mem_addr}, 32'h40);
        check("pri_wr", wr_cycles, 32'd0);
        check("pri_ready", {31'd0, monitor_ready}, 32'd1);

        // Reset in the second request cycle; late ack ignored.
        step(1, 0, 0, mk_addr(1, 8'h50), 0, 32'd0, 0);
        idle(0);
        step(0, 0, 0, 38'd0, 0, 32'd0, 1);
        step(0, 0, 0, 38'd0, 1, 32'h1111_1111, 0);
        check("mr_rd", {31'd0, mem_rd}, 32'd0);
        check("mr_addr", {24'd0, mem_addr}, 32'd0);
        check("mr_mon", MonDReg, 32'd0);
        check("mr_ready", {31'd0, monitor_ready}, 32'd1);

        // Random traffic.
        begin
            int bias;
            bias = 3;
            for (int c = 0; c < 1500; c++) begin
                int r;
                logic a, b, n, ack, rst;
                logic [37:0] j;
                if ($urandom_range(0, 39) == 0)
                    bias = $urandom_range(0, 5);
                r   = $urandom_range(0, 99);
                a   = (r < 7);
                b   = (r >= 7) && (r < 14);
                n   = (r >= 14) && (r < 21);
                if ($urandom_range(0, 24) == 0) begin
                    a = $urandom_range(0, 1) == 1;
                    b = 1'b1;
                    n = 1'b1;
                end
                j   = {$urandom_range(0, 63), $urandom};
                ack = ($urandom_range(0, 9) < bias);
                rst = ($urandom_range(0, 299) == 0);
                step(a, b, n, j, ack, $urandom, rst);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
